// File: rtl/audio_pkg.sv
// Shared types, pitch codes, ROM entry layout and the half-period table
// for the melody player.
package audio_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] PITCH_REST = 4'd0;
  localparam logic [3:0] PITCH_END  = 4'd15;
  localparam logic [3:0] PITCH_C4   = 4'd1;
  localparam logic [3:0] PITCH_E4   = 4'd5;
  localparam logic [3:0] PITCH_G4   = 4'd8;
  localparam logic [3:0] PITCH_A4   = 4'd10;
  localparam logic [3:0] PITCH_C5   = 4'd13;

  localparam int unsigned PITCH_MSB = 7;
  localparam int unsigned PITCH_LSB = 4;
  localparam int unsigned DUR_MSB   = 3;
  localparam int unsigned DUR_LSB   = 1;
  localparam int unsigned RSVD_BIT  = 0;

  localparam int unsigned SONGS    = 4;
  localparam int unsigned SONG_LEN = 64;

  typedef logic [7:0] entry_t;
  typedef logic [SONGS-1:0][SONG_LEN-1:0][7:0] rom_t;
  typedef logic [15:0][31:0] hp_table_t;

  // Equal-tempered frequencies in centi-Hz, C4 (code 1) .. C#5 (code 14).
  localparam longint unsigned NOTE_CHZ [16] = '{
    64'd0,     64'd26163, 64'd27718, 64'd29366, 64'd31113, 64'd32963,
    64'd34923, 64'd36999, 64'd39200, 64'd41530, 64'd44000, 64'd46616,
    64'd49388, 64'd52325, 64'd55437, 64'd0
  };

  function automatic hp_table_t hp_table(input longint unsigned clk_hz);
    hp_table_t t;
    t = '0;
    for (int unsigned p = 0; p < 16; p++) begin
      if (NOTE_CHZ[4'(p)] == 64'd0)
        t[4'(p)] = 32'd1;
      else
        t[4'(p)] = 32'((clk_hz * 64'd100) / (64'd2 * NOTE_CHZ[4'(p)]));
    end
    return t;
  endfunction

  function automatic entry_t make_entry(input logic [3:0] pitch, input logic [2:0] dur);
    return {pitch, dur, 1'b0};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song ROM: four 64-entry songs built at elaboration time.
module song_rom
  import audio_pkg::*;
(
  input  logic [1:0] song_sel,
  input  logic [5:0] note_idx,
  output entry_t     entry
);

  function automatic rom_t build_rom();
    rom_t r;
    for (int unsigned s = 0; s < SONGS; s++)
      for (int unsigned i = 0; i < SONG_LEN; i++)
        r[2'(s)][6'(i)] = make_entry(PITCH_END, 3'd0);
    // Song 0: 64 notes walking the scale from A4, no end marker.
    for (int unsigned i = 0; i < SONG_LEN; i++)
      r[0][6'(i)] = make_entry(4'(((i + 9) % 14) + 1), (i % 8 == 3) ? 3'd1 : 3'd0);
    r[1][0] = make_entry(PITCH_A4, 3'd0);
    r[1][1] = make_entry(PITCH_REST, 3'd1);
    r[2][0] = make_entry(PITCH_C5, 3'd0);
    r[2][1] = make_entry(PITCH_E4, 3'd0);
    r[2][2] = make_entry(PITCH_G4, 3'd1);
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  always_comb begin
    entry = ROM[song_sel][note_idx];
  end

endmodule

// File: rtl/melody_player.sv
// Song sequencer: walks a ROM song note by note, generating a square-wave
// tone per note followed by a silent articulation gap.
module melody_player
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned UNIT_TICKS = 6_250_000,
  parameter int unsigned GAP_TICKS  = 625_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] estado,
  input  logic [1:0] song_sel,
  output logic       tone,
  output logic [5:0] note_idx,
  output logic       busy
);

  localparam hp_table_t HP = hp_table(64'(CLK_HZ));
  // C4 (code 1) is the lowest pitch, so it has the longest half period.
  localparam int unsigned HP_W     = (HP[1] > 32'd2) ? $clog2(HP[1]) : 1;
  localparam int unsigned PLAY_MAX = 8 * UNIT_TICKS - GAP_TICKS;
  localparam int unsigned DUR_W    = (PLAY_MAX > 2) ? $clog2(PLAY_MAX) : 1;
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);

  state_t            state;
  logic [1:0]        sel_q;
  logic [3:0]        pitch_q;
  logic [HP_W-1:0]   hp_cnt;
  logic [HP_W-1:0]   hp_last;
  logic [DUR_W-1:0]  dur_cnt;
  logic [DUR_W-1:0]  play_last;
  entry_t            entry;
  logic [3:0]        rom_pitch;
  logic [2:0]        rom_dur;

  song_rom u_rom (
    .song_sel (sel_q),
    .note_idx (note_idx),
    .entry    (entry)
  );

  always_comb begin
    rom_pitch = entry[PITCH_MSB:PITCH_LSB];
    rom_dur   = entry[DUR_MSB:DUR_LSB];
    assert (entry[RSVD_BIT] == 1'b0);
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tone      <= 1'b0;
      note_idx  <= '0;
      sel_q     <= '0;
      pitch_q   <= '0;
      hp_cnt    <= '0;
      hp_last   <= '0;
      dur_cnt   <= '0;
      play_last <= '0;
    end else if (estado == 2'd0) begin
      state    <= S_IDLE;
      tone     <= 1'b0;
      note_idx <= '0;
      sel_q    <= song_sel;
      hp_cnt   <= '0;
      dur_cnt  <= '0;
    end else if (state != S_IDLE && song_sel != sel_q) begin
      state    <= S_LOAD;
      tone     <= 1'b0;
      note_idx <= '0;
      sel_q    <= song_sel;
      hp_cnt   <= '0;
      dur_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_LOAD;
          tone     <= 1'b0;
          note_idx <= '0;
          sel_q    <= song_sel;
        end
        S_LOAD: begin
          tone      <= 1'b0;
          hp_cnt    <= '0;
          dur_cnt   <= '0;
          pitch_q   <= rom_pitch;
          hp_last   <= HP_W'(HP[rom_pitch] - 32'd1);
          play_last <= DUR_W'((32'(rom_dur) + 32'd1) * UNIT_TICKS - GAP_TICKS - 32'd1);
          // End marker loops back to entry 0 without leaving LOAD.
          if (rom_pitch == PITCH_END)
            note_idx <= '0;
          else
            state <= S_PLAY;
        end
        S_PLAY: begin
          if (dur_cnt == play_last) begin
            state   <= S_GAP;
            tone    <= 1'b0;
            dur_cnt <= '0;
            hp_cnt  <= '0;
          end else begin
            dur_cnt <= dur_cnt + DUR_W'(1);
            if (pitch_q != PITCH_REST) begin
              if (hp_cnt == hp_last) begin
                hp_cnt <= '0;
                tone   <= ~tone;
              end else begin
                hp_cnt <= hp_cnt + HP_W'(1);
              end
            end
          end
        end
        S_GAP: begin
          tone <= 1'b0;
          if (dur_cnt == GAP_LAST) begin
            dur_cnt  <= '0;
            note_idx <= note_idx + 6'd1;
            state    <= S_LOAD;
          end else begin
            dur_cnt <= dur_cnt + DUR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with scaled-down timing parameters;
// expectations are queued as stimulus is applied and popped at each check.
module tb_melody_player;
  import audio_pkg::*;

  localparam int unsigned CLK_HZ = 44_000;
  localparam int unsigned UNIT   = 200;
  localparam int unsigned GAP    = 20;

  // Half periods at CLK_HZ = 44 kHz: floor(CLK_HZ / (2 * f)).
  localparam int HP_A4  = 50;
  localparam int HP_AS4 = 47;
  localparam int HP_B4  = 44;
  localparam int HP_C5  = 42;
  localparam int HP_CS5 = 39;
  localparam int HP_E4  = 66;
  localparam int HP_D4  = 74;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] estado;
  logic [1:0] song_sel;
  logic       tone;
  logic [5:0] note_idx;
  logic       busy;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t        sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  melody_player #(
    .CLK_HZ     (CLK_HZ),
    .UNIT_TICKS (UNIT),
    .GAP_TICKS  (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .estado   (estado),
    .song_sel (song_sel),
    .tone     (tone),
    .note_idx (note_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input int obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      e.tag = "<empty>";
      e.val = -999;
    end else begin
      e = sb.pop_front();
    end
    assert (obs === e.val && tag == e.tag) passed++;
    else $error("FAIL %s: observed %0d, expected %0d (queued %s)", tag, obs, e.val, e.tag);
  endtask

  // Starts on the LOAD cycle of a note; ends on the LOAD cycle of the next.
  task automatic watch_note(input string name, input int h, input int dur, input int nxt);
    int p, len_exp, hi_exp, tog_exp, rise_exp;
    int hi_obs, tog_obs, rise_obs, len_obs;
    logic e, e_prev, o_prev;
    logic [5:0] start_idx;
    p = (dur + 1) * int'(UNIT) - int'(GAP);
    len_exp = (dur + 1) * int'(UNIT) + 1;
    hi_exp = 0; tog_exp = 0; rise_exp = -1;
    hi_obs = 0; tog_obs = 0; rise_obs = -1; len_obs = -1;
    e_prev = 1'b0;
    for (int n = 0; n < len_exp; n++) begin
      e = (h > 0 && n >= 1 && n <= p) ? (((n - 1) / h) % 2 == 1) : 1'b0;
      if (e) begin
        hi_exp++;
        if (rise_exp < 0) rise_exp = n;
      end
      if (n > 0 && e != e_prev) tog_exp++;
      e_prev = e;
    end
    expect_val({name, ".len"}, len_exp);
    expect_val({name, ".hi"}, hi_exp);
    expect_val({name, ".rise"}, rise_exp);
    expect_val({name, ".tog"}, tog_exp);
    expect_val({name, ".idx"}, nxt);
    start_idx = note_idx;
    o_prev = tone;
    for (int n = 0; n < len_exp + 64; n++) begin
      if (n > 0 && note_idx != start_idx) begin
        len_obs = n;
        break;
      end
      if (tone) begin
        hi_obs++;
        if (rise_obs < 0) rise_obs = n;
      end
      if (n > 0 && tone != o_prev) tog_obs++;
      o_prev = tone;
      tick(1);
    end
    check({name, ".len"}, len_obs);
    check({name, ".hi"}, hi_obs);
    check({name, ".rise"}, rise_obs);
    check({name, ".tog"}, tog_obs);
    check({name, ".idx"}, int'(note_idx));
  endtask

  task automatic wait_idx(input string name, input int target, input int unsigned limit);
    expect_val(name, target);
    for (int unsigned c = 0; c < limit; c++) begin
      if (int'(note_idx) == target) break;
      tick(1);
    end
    check(name, int'(note_idx));
  endtask

  initial begin
    hp_table_t tab;
    int hi_cnt, busy_cnt;

    tab = hp_table(64'd50_000_000);
    expect_val("hp_a4_default", 56818);
    check("hp_a4_default", int'(tab[10]));

    reset = 1'b1; estado = 2'd1; song_sel = 2'd0;
    tick(3);
    expect_val("rst_tone", 0);  check("rst_tone", int'(tone));
    expect_val("rst_busy", 0);  check("rst_busy", int'(busy));
    expect_val("rst_idx", 0);   check("rst_idx", int'(note_idx));

    reset = 1'b0;
    tick(2);
    expect_val("busy_after_rel", 1); check("busy_after_rel", int'(busy));

    estado = 2'd0;
    tick(1);
    expect_val("idle_busy", 0); check("idle_busy", int'(busy));

    estado = 2'd1;
    tick(1);
    watch_note("s0n0", HP_A4, 0, 1);
    watch_note("s0n1", HP_AS4, 0, 2);
    watch_note("s0n2", HP_B4, 0, 3);
    watch_note("s0n3", HP_C5, 1, 4);
    watch_note("s0n4", HP_CS5, 0, 5);

    tick(50);
    song_sel = 2'd2;
    tick(1);
    expect_val("sel_idx", 0);  check("sel_idx", int'(note_idx));
    expect_val("sel_busy", 1); check("sel_busy", int'(busy));
    expect_val("sel_tone", 0); check("sel_tone", int'(tone));
    watch_note("s2n0", HP_C5, 0, 1);

    tick(100);
    expect_val("pre_stop_tone", 1); check("pre_stop_tone", int'(tone));
    estado = 2'd0;
    tick(1);
    expect_val("stop_tone", 0); check("stop_tone", int'(tone));
    expect_val("stop_busy", 0); check("stop_busy", int'(busy));
    expect_val("stop_idx", 0);  check("stop_idx", int'(note_idx));
    estado = 2'd1;
    tick(1);
    watch_note("s2replay", HP_C5, 0, 1);

    song_sel = 2'd1;
    tick(1);
    expect_val("s1_idx", 0); check("s1_idx", int'(note_idx));
    watch_note("s1n0", HP_A4, 0, 1);
    watch_note("s1rest", 0, 1, 2);
    tick(1);
    expect_val("end_idx", 0);  check("end_idx", int'(note_idx));
    expect_val("end_tone", 0); check("end_tone", int'(tone));
    watch_note("s1replay", HP_A4, 0, 1);

    song_sel = 2'd3;
    hi_cnt = 0; busy_cnt = 0;
    expect_val("s3_hi", 0);
    expect_val("s3_busy", 40);
    expect_val("s3_idx", 0);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (tone) hi_cnt++;
      if (busy) busy_cnt++;
    end
    check("s3_hi", hi_cnt);
    check("s3_busy", busy_cnt);
    check("s3_idx", int'(note_idx));

    song_sel = 2'd0;
    tick(1);
    wait_idx("reach63_a", 63, 20000);
    watch_note("wrap", HP_D4, 0, 0);
    wait_idx("reach63_b", 63, 20000);
    tick(190);
    expect_val("gap63_tone", 0); check("gap63_tone", int'(tone));
    expect_val("gap63_idx", 63); check("gap63_idx", int'(note_idx));

    reset = 1'b1;
    tick(1);
    expect_val("rst63_idx", 0);  check("rst63_idx", int'(note_idx));
    expect_val("rst63_tone", 0); check("rst63_tone", int'(tone));
    expect_val("rst63_busy", 0); check("rst63_busy", int'(busy));
    hi_cnt = 0;
    expect_val("rst63_hold_hi", 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (tone) hi_cnt++;
    end
    check("rst63_hold_hi", hi_cnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter UNIT_TICKS, default 6_250_000, clk cycles per duration unit (125 ms).
REQ-003 SHALL have parameter GAP_TICKS, default 625_000, silent articulation tail per note; must be less than UNIT_TICKS.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port estado  input  2  play request; nonzero = play, 0 = stop.
REQ-007 SHALL have port song_sel  input  2  song select, 0..3.
REQ-008 SHALL have port tone  output  1  registered square-wave output for the audio selector.
REQ-009 SHALL have port note_idx  output  6  ROM index of the note currently sounding.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement the FSM IDLE -> LOAD -> PLAY -> GAP -> LOAD.
REQ-012 Song ROM entry SHALL be 8 bits: pitch[7:4] and dur[3:1], with bit 0 reserved and equal to 0; each song holds 64 entries.
REQ-013 Pitch 0 SHALL be a rest (tone=0), pitch 1..14 SHALL index the half-period table, and pitch 15 SHALL be an end marker.
REQ-014 IDLE SHALL go to LOAD on the cycle after estado!=0 is sampled, with note_idx=0.
REQ-015 LOAD SHALL take one cycle: it fetches ROM[song_sel][note_idx], latches pitch and dur, and clears the tone and duration counters.
REQ-016 In LOAD, pitch 15 SHALL set note_idx to 0 and stay in LOAD (loop); a song whose entry 0 is pitch 15 SHALL hold LOAD indefinitely with tone=0.
REQ-017 PLAY SHALL run for (dur+1)*UNIT_TICKS - GAP_TICKS cycles, then go to GAP.
REQ-018 During PLAY, tone SHALL toggle each time the half-period counter reaches HP[pitch]-1; the counter then wraps to 0.
REQ-019 tone SHALL be 0 in LOAD, GAP and IDLE, and during rests.
REQ-020 GAP SHALL last GAP_TICKS cycles, then increment note_idx modulo 64 and go to LOAD; an index of 63 SHALL wrap to 0.
REQ-021 estado==0 in any state SHALL force IDLE next cycle, with tone=0 and note_idx=0 (stop has priority).
REQ-022 A change of song_sel while busy SHALL restart at LOAD with note_idx=0 next cycle; stop SHALL take priority over this restart.
REQ-023 Counters SHALL be sized from the parameters using $clog2, and overflow SHALL be impossible under legal parameters.
REQ-024 tone SHALL be registered with no combinational path from any input.

Reset
REQ-025 reset SHALL force IDLE with tone=0, note_idx=0, busy=0, all counters 0 and the song_sel shadow register 0.
REQ-026 reset SHALL take priority over estado and song_sel.
REQ-027 reset mid-note SHALL silence tone on the next clk edge.

Structure
REQ-028 Package audio_pkg SHALL hold the state enum, the pitch codes (REST=0, END=15) and the half-period table.
REQ-029 The half-period table SHALL be computed from CLK_HZ, e.g. A4 (code 10) = CLK_HZ/880 = 56818.
REQ-030 Package audio_pkg SHALL hold the ROM entry field positions.
REQ-031 Sub-module song_rom SHALL be combinational or 1-cycle, with inputs song_sel and note_idx and output entry; LOAD timing SHALL absorb a registered read.
REQ-032 The tone divider and the duration counter SHALL live in melody_player.

Verification
REQ-033 Reset with estado=1: tone=0, busy=0 during reset; busy=1 two cycles after release.
REQ-034 Song entry 0 = A4, dur=0, with defaults: tone period 113636 cycles for 5_625_000 cycles, then 625_000 cycles silent, then note_idx=1.
REQ-035 Rest entry, then end marker at index 2: tone stays 0 through the rest; note_idx returns 0 after index 2 and the first note replays.
REQ-036 estado dropped mid-PLAY: next cycle tone=0, busy=0, note_idx=0; re-assert restarts from index 0.
REQ-037 song_sel 0->2 at note_idx=5: next cycle LOAD with note_idx=0, and song 2 entry 0 pitch heard.
REQ-038 reset asserted during GAP at note_idx=63: IDLE, note_idx=0; no wrap glitch on tone.
